// File: rtl/pipeline_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : pipeline_arbiter
//  Description : Four-way round-robin arbiter and transfer sequencer feeding
//                the input of a 3-stage handshake pipeline. It grants one
//                requester, latches its byte, raises pipe_DIR, waits for the
//                pipeline ack, and then returns a one-cycle ack. A four-phase
//                release (pipe_ack low and the request withdrawn) completes
//                each transfer.
//  Options     : PIPELINE_ARB_TIMEOUT_EN enables a SEND-state timeout that
//                aborts the transfer and sets a sticky err flag.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            ack_to_req,
    output logic [3:0]            abort_to_req,
    output logic                  pipe_DIR,
    output logic [DATA_W-1:0]     pipe_data,
    input  logic                  pipe_ack,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              r_state,    w_state_nx;
    logic [1:0]          r_rr_ptr,   w_rr_ptr_nx;
    logic                r_pipe_dir, w_pipe_dir_nx;
    logic [DATA_W-1:0]   r_pipe_data, w_pipe_data_nx;
    logic [3:0]          r_ack,      w_ack_nx;
    logic [1:0]          r_grant_id, w_grant_id_nx;
    logic                r_busy,     w_busy_nx;

`ifdef PIPELINE_ARB_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [3:0]          r_abort,    w_abort_nx;
    logic                r_err,      w_err_nx;
    logic [c_CNT_W-1:0]  r_cnt,      w_cnt_nx;
`endif

    // Round-robin pick: rotate req so rr_ptr lands at bit 0, then take the
    // lowest set bit and rotate the offset back.
    logic [7:0] w_req_rot2;
    logic [3:0] w_req_rot;
    logic [1:0] w_off;
    logic [1:0] w_sel;

    assign w_req_rot2 = {req, req} >> r_rr_ptr;
    assign w_req_rot  = w_req_rot2[3:0];

    // Priority encoder over the rotated request vector.
    always_comb begin
        w_off = 2'd3;
        if (w_req_rot[0])      w_off = 2'd0;
        else if (w_req_rot[1]) w_off = 2'd1;
        else if (w_req_rot[2]) w_off = 2'd2;
        else                   w_off = 2'd3;
    end

    assign w_sel = r_rr_ptr + w_off;

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        w_state_nx     = r_state;
        w_rr_ptr_nx    = r_rr_ptr;
        w_pipe_dir_nx  = r_pipe_dir;
        w_pipe_data_nx = r_pipe_data;
        w_ack_nx       = 4'b0000;
        w_grant_id_nx  = r_grant_id;
`ifdef PIPELINE_ARB_TIMEOUT_EN
        w_abort_nx     = 4'b0000;
        w_err_nx       = r_err;
        w_cnt_nx       = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_grant_id_nx  = w_sel;
                    w_pipe_data_nx = req_data[w_sel*DATA_W +: DATA_W];
                    w_pipe_dir_nx  = 1'b1;
                    w_state_nx     = S_SEND;
`ifdef PIPELINE_ARB_TIMEOUT_EN
                    w_cnt_nx       = '0;
`endif
                end
            end
            S_SEND: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (pipe_ack) begin
                    w_pipe_dir_nx = 1'b0;
                    w_ack_nx      = 4'b0001 << r_grant_id;
                    w_rr_ptr_nx   = r_grant_id + 2'd1;
                    w_state_nx    = S_RELEASE;
                end
`ifdef PIPELINE_ARB_TIMEOUT_EN
                else if (r_cnt == c_CNT_LAST) begin
                    w_pipe_dir_nx = 1'b0;
                    w_abort_nx    = 4'b0001 << r_grant_id;
                    w_err_nx      = 1'b1;
                    w_rr_ptr_nx   = r_grant_id + 2'd1;
                    w_state_nx    = S_RELEASE;
                end else begin
                    w_cnt_nx      = r_cnt + 1'b1;
                end
`endif
            end
            S_RELEASE: begin
                if (!pipe_ack && !req[r_grant_id]) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx    = S_IDLE;
                w_pipe_dir_nx = 1'b0;
            end
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= 2'd0;
            r_pipe_dir  <= 1'b0;
            r_pipe_data <= '0;
            r_ack       <= 4'b0000;
            r_grant_id  <= 2'd0;
            r_busy      <= 1'b0;
`ifdef PIPELINE_ARB_TIMEOUT_EN
            r_abort     <= 4'b0000;
            r_err       <= 1'b0;
            r_cnt       <= '0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_rr_ptr    <= w_rr_ptr_nx;
            r_pipe_dir  <= w_pipe_dir_nx;
            r_pipe_data <= w_pipe_data_nx;
            r_ack       <= w_ack_nx;
            r_grant_id  <= w_grant_id_nx;
            r_busy      <= w_busy_nx;
`ifdef PIPELINE_ARB_TIMEOUT_EN
            r_abort     <= w_abort_nx;
            r_err       <= w_err_nx;
            r_cnt       <= w_cnt_nx;
`endif
        end
    end

    assign pipe_DIR   = r_pipe_dir;
    assign pipe_data  = r_pipe_data;
    assign ack_to_req = r_ack;
    assign grant_id   = r_grant_id;
    assign busy       = r_busy;

`ifdef PIPELINE_ARB_TIMEOUT_EN
    assign abort_to_req = r_abort;
    assign err          = r_err;
`else
    assign abort_to_req = 4'b0000;
    assign err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipeline_arbiter
//  Description : Scoreboard bench for pipeline_arbiter. Stimulus pushes the
//                expected grant/ack/abort events; a negedge monitor pops and
//                compares them as the DUT presents them.
//  Options     : PIPELINE_ARB_TIMEOUT_EN adds the timeout scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_arbiter;

    localparam int c_DATA_W = 8;
    localparam int K_GRANT  = 0;
    localparam int K_ACK    = 1;
    localparam int K_ABORT  = 2;

    logic                  clk;
    logic                  reset;
    logic [3:0]            req;
    logic [4*c_DATA_W-1:0] req_data;
    logic [3:0]            ack_to_req;
    logic [3:0]            abort_to_req;
    logic                  pipe_DIR;
    logic [c_DATA_W-1:0]   pipe_data;
    logic                  pipe_ack;
    logic [1:0]            grant_id;
    logic                  busy;
    logic                  err;

    pipeline_arbiter #(
        .DATA_W  (c_DATA_W),
        .TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .ack_to_req   (ack_to_req),
        .abort_to_req (abort_to_req),
        .pipe_DIR     (pipe_DIR),
        .pipe_data    (pipe_data),
        .pipe_ack     (pipe_ack),
        .grant_id     (grant_id),
        .busy         (busy),
        .err          (err)
    );

    typedef struct {
        int         kind;
        logic [1:0] id;
        logic [7:0] data;
        logic [3:0] vec;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.kind = K_GRANT; e.id = id; e.data = data; e.vec = 4'b0000;
        q.push_back(e);
    endtask

    task automatic push_resp(input int kind, input logic [3:0] vec);
        exp_t e;
        e.kind = kind; e.id = 2'd0; e.data = 8'h00; e.vec = vec;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per event the DUT presents.
    logic       prev_dir = 1'b0;
    logic [7:0] cur_data = 8'h00;
    exp_t       m_e;

    always @(negedge clk) begin
        if (pipe_DIR === 1'b1 && prev_dir !== 1'b1) begin
            if (q.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL unexpected_grant: got id %0d data %0h expected none", grant_id, pipe_data);
            end else begin
                m_e = q.pop_front();
                chk("grant_kind", m_e.kind, K_GRANT);
                chk("grant_id", {30'd0, grant_id}, {30'd0, m_e.id});
                chk("grant_data", {24'd0, pipe_data}, {24'd0, m_e.data});
                cur_data = m_e.data;
            end
        end else if (pipe_DIR === 1'b1) begin
            chk("hold_data", {24'd0, pipe_data}, {24'd0, cur_data});
        end
        if (ack_to_req !== 4'b0000 && !$isunknown(ack_to_req)) begin
            if (q.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL unexpected_ack: got %b expected none", ack_to_req);
            end else begin
                m_e = q.pop_front();
                chk("ack_kind", m_e.kind, K_ACK);
                chk("ack_vec", {28'd0, ack_to_req}, {28'd0, m_e.vec});
            end
        end
        if (abort_to_req !== 4'b0000 && !$isunknown(abort_to_req)) begin
            if (q.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL unexpected_abort: got %b expected none", abort_to_req);
            end else begin
                m_e = q.pop_front();
                chk("abort_kind", m_e.kind, K_ABORT);
                chk("abort_vec", {28'd0, abort_to_req}, {28'd0, m_e.vec});
            end
        end
        prev_dir = pipe_DIR;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        logic [1:0] g;
        reset    = 1'b1;
        req      = 4'b0000;
        req_data = '0;
        pipe_ack = 1'b0;
        tick();
        tick();
        chk("rst_dir",   {31'd0, pipe_DIR}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_gid",   {30'd0, grant_id}, 32'd0);
        chk("rst_ack",   {28'd0, ack_to_req}, 32'd0);
        chk("rst_abort", {28'd0, abort_to_req}, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        chk("rst_data",  {24'd0, pipe_data}, 32'd0);
        reset = 1'b0;
        tick();

        // Single transfer from requester 2.
        req_data[2*8 +: 8] = 8'hA5;
        req = 4'b0100;
        push_grant(2'd2, 8'hA5);
        tick();
        chk("t1_dir",  {31'd0, pipe_DIR}, 32'd1);
        chk("t1_gid",  {30'd0, grant_id}, 32'd2);
        chk("t1_data", {24'd0, pipe_data}, 32'hA5);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        tick(); tick(); tick();
        chk("t1_wait_ack", {28'd0, ack_to_req}, 32'd0);
        pipe_ack = 1'b1;
        push_resp(K_ACK, 4'b0100);
        tick();
        chk("t1_ack",     {28'd0, ack_to_req}, 32'b0100);
        chk("t1_dir_low", {31'd0, pipe_DIR}, 32'd0);
        tick();
        chk("t1_ack_pulse", {28'd0, ack_to_req}, 32'd0);
        chk("t1_rel_busy",  {31'd0, busy}, 32'd1);
        req = 4'b0000;
        pipe_ack = 1'b0;
        tick();
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        chk("t1_gid_keep",  {30'd0, grant_id}, 32'd2);

        // Round-robin from a fresh reset with all four requesting.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_data = 32'h13121110;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            g = 2'(i);
            push_grant(g, 8'h10 + {6'd0, g});
            tick();
            chk("rr_gid", {30'd0, grant_id}, {30'd0, g});
            tick();
            pipe_ack = 1'b1;
            push_resp(K_ACK, 4'b0001 << g);
            tick();
            chk("rr_ack", {28'd0, ack_to_req}, {28'd0, 4'b0001 << g});
            req[g] = 1'b0;
            pipe_ack = 1'b0;
            tick();
            chk("rr_idle", {31'd0, busy}, 32'd0);
            req[g] = 1'b1;
        end
        req = 4'b0000;
        tick();

        // Withdrawal and data change while in SEND.
        req_data[1*8 +: 8] = 8'h3C;
        req = 4'b0010;
        push_grant(2'd1, 8'h3C);
        tick();
        chk("wd_gid", {30'd0, grant_id}, 32'd1);
        req = 4'b0000;
        req_data[1*8 +: 8] = 8'hFF;
        tick(); tick();
        chk("wd_data", {24'd0, pipe_data}, 32'h3C);
        chk("wd_dir",  {31'd0, pipe_DIR}, 32'd1);
        pipe_ack = 1'b1;
        push_resp(K_ACK, 4'b0010);
        tick();
        chk("wd_ack", {28'd0, ack_to_req}, 32'b0010);
        pipe_ack = 1'b0;
        tick();
        chk("wd_idle", {31'd0, busy}, 32'd0);

        // Four-phase hold: pipe_ack stays high after the ack.
        req_data[0*8 +: 8] = 8'h40;
        req_data[1*8 +: 8] = 8'h41;
        req = 4'b0011;
        push_grant(2'd0, 8'h40);
        tick();
        chk("fp_gid0", {30'd0, grant_id}, 32'd0);
        pipe_ack = 1'b1;
        push_resp(K_ACK, 4'b0001);
        tick();
        chk("fp_ack0", {28'd0, ack_to_req}, 32'b0001);
        req = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fp_hold_dir",  {31'd0, pipe_DIR}, 32'd0);
            chk("fp_hold_busy", {31'd0, busy}, 32'd1);
        end
        pipe_ack = 1'b0;
        push_grant(2'd1, 8'h41);
        tick();
        chk("fp_rel_dir",  {31'd0, pipe_DIR}, 32'd0);
        chk("fp_rel_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("fp_dir1", {31'd0, pipe_DIR}, 32'd1);
        chk("fp_gid1", {30'd0, grant_id}, 32'd1);
        pipe_ack = 1'b1;
        push_resp(K_ACK, 4'b0010);
        tick();
        req = 4'b0000;
        pipe_ack = 1'b0;
        tick();

        // Reset in the middle of a transfer.
        req_data[0*8 +: 8] = 8'h50;
        req_data[3*8 +: 8] = 8'h63;
        req = 4'b1001;
        push_grant(2'd3, 8'h63);
        tick();
        chk("mr_gid3", {30'd0, grant_id}, 32'd3);
        tick();
        reset = 1'b1;
        tick();
        chk("mr_dir",  {31'd0, pipe_DIR}, 32'd0);
        chk("mr_ack",  {28'd0, ack_to_req}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_gid",  {30'd0, grant_id}, 32'd0);
        reset = 1'b0;
        push_grant(2'd0, 8'h50);
        tick();
        chk("mr_regrant", {30'd0, grant_id}, 32'd0);
        chk("mr_redata",  {24'd0, pipe_data}, 32'h50);
        pipe_ack = 1'b1;
        push_resp(K_ACK, 4'b0001);
        tick();
        req = 4'b0000;
        pipe_ack = 1'b0;
        tick();

`ifdef PIPELINE_ARB_TIMEOUT_EN
        // Timeout with TIMEOUT=4 on requester 3.
        req_data[3*8 +: 8] = 8'h7E;
        req = 4'b1000;
        push_grant(2'd3, 8'h7E);
        tick();
        chk("to_err_pre", {31'd0, err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_dir_hold", {31'd0, pipe_DIR}, 32'd1);
            chk("to_no_abort", {28'd0, abort_to_req}, 32'd0);
        end
        push_resp(K_ABORT, 4'b1000);
        tick();
        chk("to_abort", {28'd0, abort_to_req}, 32'b1000);
        chk("to_err",   {31'd0, err}, 32'd1);
        chk("to_dir",   {31'd0, pipe_DIR}, 32'd0);
        chk("to_noack", {28'd0, ack_to_req}, 32'd0);
        req = 4'b0000;
        tick();
        chk("to_idle", {31'd0, busy}, 32'd0);
        req_data[0*8 +: 8] = 8'h21;
        req = 4'b0001;
        push_grant(2'd0, 8'h21);
        tick();
        pipe_ack = 1'b1;
        push_resp(K_ACK, 4'b0001);
        tick();
        chk("to_ack_after", {28'd0, ack_to_req}, 32'b0001);
        req = 4'b0000;
        pipe_ack = 1'b0;
        tick();
        chk("to_err_sticky", {31'd0, err}, 32'd1);
`else
        chk("no_err",   {31'd0, err}, 32'd0);
        chk("no_abort", {28'd0, abort_to_req}, 32'd0);
`endif

        tick();
        tick();
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
